// File: rtl/fp_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_alu_pkg
//  Description : Shared definitions for the floating-point ALU front end:
//                loader state encoding, operand class codes, core opcodes
//                and datapath widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_alu_pkg;

    localparam int FP_W   = 32;
    localparam int BYTE_W = 8;

    // Loader state encoding; value 3 is illegal and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Operand class codes; 6 and 7 are unused.
    localparam logic [2:0] CLS_NORMAL = 3'd0;
    localparam logic [2:0] CLS_ZERO   = 3'd1;
    localparam logic [2:0] CLS_SUBN   = 3'd2;
    localparam logic [2:0] CLS_INF    = 3'd3;
    localparam logic [2:0] CLS_QNAN   = 3'd4;
    localparam logic [2:0] CLS_SNAN   = 3'd5;

    // Operation codes understood by the compute core.
    localparam logic [1:0] OPC_ADD = 2'd0;
    localparam logic [1:0] OPC_SUB = 2'd1;
    localparam logic [1:0] OPC_MUL = 2'd2;
    localparam logic [1:0] OPC_DIV = 2'd3;

endpackage
`default_nettype wire

// File: rtl/fp_classify.sv
`default_nettype none
// ============================================================================
//  Module      : fp_classify
//  Description : Combinational IEEE-754 single-precision classifier.
//                The sign bit does not influence the class.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_classify
    import fp_alu_pkg::*;
(
    input  logic [FP_W-1:0] fp_i,
    output logic [2:0]      cls_o
);

    logic [7:0]  w_exp;
    logic [22:0] w_man;
    logic        w_sign_unused;

    assign w_exp         = fp_i[30:23];
    assign w_man         = fp_i[22:0];
    assign w_sign_unused = fp_i[31];

    // Decode exponent/mantissa fields into a class code.
    always_comb begin
        cls_o = CLS_NORMAL;
        if (w_exp == 8'h00) begin
            cls_o = (w_man == 23'd0) ? CLS_ZERO : CLS_SUBN;
        end else if (w_exp == 8'hFF) begin
            if (w_man == 23'd0) begin
                cls_o = CLS_INF;
            end else if (w_man[22]) begin
                cls_o = CLS_QNAN;
            end else begin
                cls_o = CLS_SNAN;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : fp_operand_loader
//  Description : Byte-serial operand loader. Captures a start/opcode request
//                and eight bytes, assembles operands A and B, classifies
//                them and holds them for the FP core behind valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_operand_loader
    import fp_alu_pkg::*;
#(
    parameter int unsigned MSB_FIRST = 1
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] in,
    input  logic              start,
    input  logic [1:0]        opcode,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [FP_W-1:0]   op_a,
    output logic [FP_W-1:0]   op_b,
    output logic [1:0]        op_code,
    output logic [2:0]        a_class,
    output logic [2:0]        b_class,
    output logic              busy,
    output logic [1:0]        state,
    output logic [2:0]        byte_idx
);

    state_e            state_q;
    logic [2:0]        byte_idx_q;
    logic [FP_W-1:0]   op_a_q;
    logic [FP_W-1:0]   op_b_q;
    logic [FP_W-1:0]   op_a_d;
    logic [FP_W-1:0]   op_b_d;
    logic [1:0]        op_code_q;
    logic [2:0]        a_class_q;
    logic [2:0]        b_class_q;
    logic              op_valid_q;
    logic              busy_q;

    logic [2:0]        w_slot;
    logic [1:0]        w_lane;
    logic [4:0]        w_base;
    logic [2:0]        w_a_cls;
    logic [2:0]        w_b_cls;

    // Insert the current bus byte into its operand slot. In IDLE the slot is
    // always 0 so a start cycle lands byte 0 regardless of byte_idx.
    always_comb begin
        op_a_d = op_a_q;
        op_b_d = op_b_q;
        w_slot = (state_q == ST_LOAD) ? byte_idx_q : 3'd0;
        w_lane = (MSB_FIRST != 0) ? (2'd3 - w_slot[1:0]) : w_slot[1:0];
        w_base = {w_lane, 3'b000};
        if (w_slot[2]) begin
            op_b_d[w_base +: BYTE_W] = in;
        end else begin
            op_a_d[w_base +: BYTE_W] = in;
        end
    end

    // Classify the words as they will look after this edge, so that the
    // classes are ready in the same edge that captures byte 7.
    fp_classify u_cls_a (
        .fp_i  (op_a_d),
        .cls_o (w_a_cls)
    );

    fp_classify u_cls_b (
        .fp_i  (op_b_d),
        .cls_o (w_b_cls)
    );

    // Loader FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            byte_idx_q <= 3'd0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_code_q  <= 2'd0;
            a_class_q  <= CLS_NORMAL;
            b_class_q  <= CLS_NORMAL;
            op_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_code_q  <= opcode;
                        op_a_q     <= op_a_d;
                        op_b_q     <= op_b_d;
                        byte_idx_q <= 3'd1;
                        state_q    <= ST_LOAD;
                        busy_q     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    op_a_q     <= op_a_d;
                    op_b_q     <= op_b_d;
                    // Wraps from 7 to 0 on the final byte.
                    byte_idx_q <= byte_idx_q + 3'd1;
                    if (byte_idx_q == 3'd7) begin
                        a_class_q  <= w_a_cls;
                        b_class_q  <= w_b_cls;
                        op_valid_q <= 1'b1;
                        state_q    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (op_ready) begin
                        op_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    byte_idx_q <= 3'd0;
                    op_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign op_valid = op_valid_q;
    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign op_code  = op_code_q;
    assign a_class  = a_class_q;
    assign b_class  = b_class_q;
    assign busy     = busy_q;
    assign state    = state_q;
    assign byte_idx = byte_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_operand_loader
//  Description : Scoreboard bench for fp_operand_loader. Stimulus pushes the
//                hand-computed expected operands; monitors compare whenever
//                a DUT presents op_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_operand_loader;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  code;
        logic [2:0]  ca;
        logic [2:0]  cb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_b = 8'h00;
    logic        start_m = 1'b0;
    logic        start_l = 1'b0;
    logic [1:0]  opcode = 2'd0;
    logic        op_ready = 1'b0;

    logic        vld_m, busy_m, vld_l, busy_l;
    logic [31:0] a_m, b_m, a_l, b_l;
    logic [1:0]  code_m, st_m, code_l, st_l;
    logic [2:0]  ca_m, cb_m, idx_m, ca_l, cb_l, idx_l;

    int tests = 0;
    int fails = 0;

    exp_t q_m[$];
    exp_t q_l[$];

    always #5 clk = ~clk;

    fp_operand_loader #(.MSB_FIRST(1)) dut_m (
        .clk(clk), .rst_n(rst_n), .in(in_b), .start(start_m), .opcode(opcode),
        .op_valid(vld_m), .op_ready(op_ready), .op_a(a_m), .op_b(b_m),
        .op_code(code_m), .a_class(ca_m), .b_class(cb_m), .busy(busy_m),
        .state(st_m), .byte_idx(idx_m)
    );

    fp_operand_loader #(.MSB_FIRST(0)) dut_l (
        .clk(clk), .rst_n(rst_n), .in(in_b), .start(start_l), .opcode(opcode),
        .op_valid(vld_l), .op_ready(op_ready), .op_a(a_l), .op_b(b_l),
        .op_code(code_l), .a_class(ca_l), .b_class(cb_l), .busy(busy_l),
        .state(st_l), .byte_idx(idx_l)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitors: pop on each rising op_valid, re-check held values every
    // valid cycle, and flag op_valid surviving a completed handshake.
    exp_t cur_m, cur_l;
    logic pv_m = 1'b0, pv_l = 1'b0, pr = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pv_m = 1'b0;
            pv_l = 1'b0;
            pr   = 1'b0;
        end else begin
            if (vld_m) begin
                if (pv_m && pr) chk("m_valid_after_hs", 32'(vld_m), 32'd0);
                if (!pv_m) begin
                    if (q_m.size() == 0) chk("m_unexpected_valid", 32'(vld_m), 32'd0);
                    else cur_m = q_m.pop_front();
                end
                chk("m_op_a", a_m, cur_m.a);
                chk("m_op_b", b_m, cur_m.b);
                chk("m_op_code", 32'(code_m), 32'(cur_m.code));
                chk("m_a_class", 32'(ca_m), 32'(cur_m.ca));
                chk("m_b_class", 32'(cb_m), 32'(cur_m.cb));
            end
            if (vld_l) begin
                if (pv_l && pr) chk("l_valid_after_hs", 32'(vld_l), 32'd0);
                if (!pv_l) begin
                    if (q_l.size() == 0) chk("l_unexpected_valid", 32'(vld_l), 32'd0);
                    else cur_l = q_l.pop_front();
                end
                chk("l_op_a", a_l, cur_l.a);
                chk("l_op_b", b_l, cur_l.b);
                chk("l_op_code", 32'(code_l), 32'(cur_l.code));
                chk("l_a_class", 32'(ca_l), 32'(cur_l.ca));
                chk("l_b_class", 32'(cb_l), 32'(cur_l.cb));
            end
            pv_m = vld_m;
            pv_l = vld_l;
            pr   = op_ready;
        end
    end

    // Issue one request plus eight bytes (byte 0 in bits 63:56).
    // Returns #1 after the edge that captures byte 7.
    task automatic load(input bit lsb, input logic [1:0] opc, input logic [63:0] bytes,
                        input logic [31:0] ea, input logic [31:0] eb,
                        input logic [2:0] eca, input logic [2:0] ecb);
        exp_t e;
        e.a = ea; e.b = eb; e.code = opc; e.ca = eca; e.cb = ecb;
        if (lsb) q_l.push_back(e); else q_m.push_back(e);
        opcode = opc;
        in_b   = bytes[63:56];
        if (lsb) start_l = 1'b1; else start_m = 1'b1;
        @(posedge clk); #1;
        start_m = 1'b0;
        start_l = 1'b0;
        chk("first_byte_idx", 32'(lsb ? idx_l : idx_m), 32'd1);
        chk("first_state", 32'(lsb ? st_l : st_m), 32'd1);
        for (int i = 1; i < 8; i++) begin
            in_b = bytes[63-8*i -: 8];
            @(posedge clk); #1;
        end
        in_b = 8'h00;
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_m(input string tag);
        chk({tag, "_valid"}, 32'(vld_m), 32'd0);
        chk({tag, "_state"}, 32'(st_m), 32'd0);
        chk({tag, "_idx"}, 32'(idx_m), 32'd0);
        chk({tag, "_busy"}, 32'(busy_m), 32'd0);
        chk({tag, "_a"}, a_m, 32'd0);
        chk({tag, "_b"}, b_m, 32'd0);
        chk({tag, "_code"}, 32'(code_m), 32'd0);
        chk({tag, "_cls"}, {26'd0, ca_m, cb_m}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        #3;
        chk_reset_m("reset");
        chk("reset_state_l", 32'(st_l), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // Basic load with op_ready held high: op_valid for exactly one cycle.
        op_ready = 1'b1;
        load(0, 2'd2, 64'h3F800000_40000000, 32'h3F800000, 32'h40000000, 3'd0, 3'd0);
        chk("basic_valid", 32'(vld_m), 32'd1);
        chk("basic_state_hold", 32'(st_m), 32'd2);
        chk("basic_idx_wrap", 32'(idx_m), 32'd0);
        tick();
        chk("basic_valid_drop", 32'(vld_m), 32'd0);
        chk("basic_state_idle", 32'(st_m), 32'd0);
        chk("basic_busy_idle", 32'(busy_m), 32'd0);

        // Backpressure: hold with start pulses and noise on the bus.
        op_ready = 1'b0;
        load(0, 2'd1, 64'h7FC00000_80000000, 32'h7FC00000, 32'h80000000, 3'd4, 3'd1);
        for (int i = 0; i < 5; i++) begin
            start_m = i[0];
            in_b    = 8'($urandom);
            opcode  = 2'($urandom);
            tick();
            chk("bp_state", 32'(st_m), 32'd2);
            chk("bp_idx", 32'(idx_m), 32'd0);
            chk("bp_valid", 32'(vld_m), 32'd1);
            chk("bp_busy", 32'(busy_m), 32'd1);
        end
        start_m  = 1'b0;
        op_ready = 1'b1;
        tick();
        chk("bp_release_state", 32'(st_m), 32'd0);
        chk("bp_release_valid", 32'(vld_m), 32'd0);

        // Classification corners.
        load(0, 2'd0, 64'h00000001_7F800001, 32'h00000001, 32'h7F800001, 3'd2, 3'd5);
        tick();
        load(0, 2'd3, 64'hFF800000_3F800000, 32'hFF800000, 32'h3F800000, 3'd3, 3'd0);
        tick();

        // Reset in the middle of a load.
        opcode  = 2'd1;
        in_b    = 8'h11;
        start_m = 1'b1;
        tick();
        start_m = 1'b0;
        in_b = 8'h22; tick();
        in_b = 8'h33; tick();
        in_b = 8'h44; tick();
        chk("mid_idx", 32'(idx_m), 32'd4);
        chk("mid_state", 32'(st_m), 32'd1);
        chk("mid_busy", 32'(busy_m), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_m("async_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        load(0, 2'd2, 64'hC0490FDB_00800000, 32'hC0490FDB, 32'h00800000, 3'd0, 3'd0);
        tick();

        // LSB-first byte order on the second instance.
        load(1, 2'd1, 64'h0000803F_00000040, 32'h3F800000, 32'h40000000, 3'd0, 3'd0);
        tick();
        chk("lsb_state_idle", 32'(st_l), 32'd0);

        // Back-to-back: start in the handshake cycle is ignored.
        load(0, 2'd2, 64'h40490FDB_7F800000, 32'h40490FDB, 32'h7F800000, 3'd0, 3'd3);
        start_m = 1'b1;
        opcode  = 2'd1;
        in_b    = 8'hAA;
        tick();
        chk("b2b_hs_state", 32'(st_m), 32'd0);
        chk("b2b_hs_idx", 32'(idx_m), 32'd0);
        load(0, 2'd3, 64'h80000001_7FFFFFFF, 32'h80000001, 32'h7FFFFFFF, 3'd2, 3'd4);
        tick();

        repeat (3) tick();
        chk("m_queue_drained", 32'(q_m.size()), 32'd0);
        chk("l_queue_drained", 32'(q_l.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
